reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised general-purpose register file with two asynchronous read ports and two write ports: immediate load and result writeback. Adds a per-register pending-write scoreboard: an issue port increments a saturating counter and each writeback decrements it. The core sequencer uses the busy flags to stall on read-after-write hazards. Sits between the decode/issue stage and the execute/writeback stage of the core datapath.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 16, number of registers (2..256, need not be a power of two)
ADDR_W, 4, register address width; must satisfy 2**ADDR_W >= NUM_REGS
PEND_W, 2, width of each per-register pending-write counter (max outstanding = 2**PEND_W-1)
ZERO_REG, 0, 1 = register 0 hardwired to zero, never written, never busy

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
rs1  in  ADDR_W  read address, port 1
rs2  in  ADDR_W  read address, port 2
out_rs1  out  DATA_W  read data, port 1 (combinational)
out_rs2  out  DATA_W  read data, port 2 (combinational)
rs1_busy  out  1  register rs1 has outstanding writeback(s)
rs2_busy  out  1  register rs2 has outstanding writeback(s)
rd_imm  in  ADDR_W  immediate write address
write_imm  in  DATA_W  immediate write data
write_en_imm  in  1  immediate write enable
rd_wb  in  ADDR_W  writeback address
write_reg_data  in  DATA_W  writeback data
write_reg  in  1  writeback enable; retires one pending write
issue_valid  in  1  mark one pending write on issue_rd
issue_rd  in  ADDR_W  destination of issued instruction
issue_ready  out  1  issue accepted this cycle
err_underflow  out  1  sticky: writeback to register with zero pending count

Behaviour:
- Reset (async, any time, including mid-operation): all registers = 0, all pending counters = 0, err_underflow = 0. The busy outputs are therefore 0 and issue_ready is 1 (for a legal issue_rd).
- Reads are combinational: out_rsN = regs[rsN]. An address >= NUM_REGS reads 0 and busy 0. With ZERO_REG=1, address 0 reads 0 and busy 0.
- Writes take effect on the rising clk edge, visible on reads the following cycle (no bypass unless the optional feature is compiled in).
- Both write enables on the same address: write_imm wins the data. The writeback still decrements the pending counter.
- Different addresses: both writes occur in the same cycle.
- Writes to address >= NUM_REGS, or to 0 with ZERO_REG=1, are dropped. The counter is untouched and err_underflow is not set.
- Immediate writes never change pending counters.
- issue_ready = 1 when issue_rd >= NUM_REGS (issue is ignored), when ZERO_REG=1 and issue_rd = 0, or when cnt[issue_rd] < max. Otherwise it is 0.
- Counter update per register, per cycle:
  - inc = issue_valid & issue_ready & (issue_rd matches)
  - dec = write_reg & (rd_wb matches) & cnt != 0
  - inc & dec: cnt unchanged
  - inc only: cnt+1
  - dec only: cnt-1
- A writeback while cnt = 0 writes the data, leaves cnt = 0 and sets err_underflow. err_underflow stays set until reset.
- Issue at saturation: issue_ready = 0 and the counter holds. The issuer must hold issue_valid until ready.
- busy = (cnt[addr] != 0), from registered state only, in the baseline build.

Optional Feature:
REGFILE_BYPASS_EN. When defined:
- Each read port returns same-cycle write data if its address matches an active write, with write_imm taking priority over write_reg_data.
- rsN_busy reflects the same-cycle retire: busy = (cnt - dec_this_cycle) != 0. A register whose last outstanding write lands this cycle reads the new data unstalled.
When undefined: reads and busy come from registered state only, giving one extra stall cycle after the final writeback.

Test Plan:
1. Assert reset mid-run after loading regs 3 and 5 → all out_rs* = 0, busy = 0, issue_ready = 1, err_underflow = 0, asynchronously and before the next edge.
2. write_en_imm rd_imm=7 data=0xDEADBEEF and write_reg rd_wb=7 data=0x12345678 with cnt[7]=1, same cycle → reg7 = 0xDEADBEEF, cnt[7] = 0, rs1=7 busy = 0 next cycle.
3. Issue to reg 2 three times (PEND_W=2) → issue_ready drops to 0 on the 4th attempt and cnt stays 3. Three writebacks → busy clears after the third. Issue and writeback to 2 in the same cycle keep cnt unchanged.
4. Writeback to reg 9 with cnt = 0, data 0xA5A5A5A5 → reg9 = 0xA5A5A5A5, err_underflow = 1 and stays 1 until reset.
5. ZERO_REG=1, NUM_REGS=12: write 0xFFFFFFFF to regs 0 and 13, issue to 0 → reads of 0 and 13 = 0, busy = 0, issue_ready = 1, counters unchanged.
6. With REGFILE_BYPASS_EN: cnt[4]=1, writeback rd_wb=4 data=0x55 while rs2=4 → out_rs2 = 0x55 and rs2_busy = 0 in the same cycle. Without the macro: rs2_busy = 1 and the old value is read that cycle.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, immediate and writeback write ports,
// and a per-register saturating pending-write scoreboard. Optional macro: REGFILE_BYPASS_EN.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int PEND_W   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] out_rs1,
    output logic [DATA_W-1:0] out_rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic [ADDR_W-1:0] rd_imm,
    input  logic [DATA_W-1:0] write_imm,
    input  logic              write_en_imm,
    input  logic [ADDR_W-1:0] rd_wb,
    input  logic [DATA_W-1:0] write_reg_data,
    input  logic              write_reg,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    output logic              err_underflow
);
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [PEND_W-1:0]   cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                imm_ok;
    logic                wb_ok;
    logic                iss_ok;
    logic [ADDR_W-1:0]   raddr [2];
    logic [DATA_W-1:0]   rdata [2];
    logic                rbusy [2];

    // Out-of-range addresses and a hardwired zero register are treated as absent.
    function automatic logic legal(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !(ZERO_REG && (a == '0));
    endfunction

    assign issue_ready = !legal(issue_rd) || (cnt[issue_rd] != CNT_MAX);

    always_comb begin
        imm_ok = write_en_imm && legal(rd_imm);
        wb_ok  = write_reg && legal(rd_wb);
        iss_ok = issue_valid && issue_ready && legal(issue_rd);
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = iss_ok && (32'(issue_rd) == i);
            dec[i] = wb_ok && (32'(rd_wb) == i) && (cnt[i] != '0);
        end
    end

    assign raddr[0] = rs1;
    assign raddr[1] = rs2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (legal(raddr[p])) begin
`ifdef REGFILE_BYPASS_EN
                if (imm_ok && (rd_imm == raddr[p])) begin
                    rdata[p] = write_imm;
                end else if (wb_ok && (rd_wb == raddr[p])) begin
                    rdata[p] = write_reg_data;
                end else begin
                    rdata[p] = regs[raddr[p]];
                end
                // A retiring final writeback releases the stall in the same cycle.
                rbusy[p] = (cnt[raddr[p]] - PEND_W'(dec[raddr[p]])) != '0;
`else
                rdata[p] = regs[raddr[p]];
                rbusy[p] = cnt[raddr[p]] != '0;
`endif
            end
        end
    end

    assign out_rs1  = rdata[0];
    assign out_rs2  = rdata[1];
    assign rs1_busy = rbusy[0];
    assign rs2_busy = rbusy[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                cnt[i]  <= '0;
            end
            err_underflow <= 1'b0;
        end else begin
            if (wb_ok) begin
                regs[rd_wb] <= write_reg_data;
                if (cnt[rd_wb] == '0) begin
                    err_underflow <= 1'b1;
                end
            end
            // Placed after the writeback so the immediate wins on an address collision.
            if (imm_ok) begin
                regs[rd_imm] <= write_imm;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc[i] != dec[i]) begin
                    cnt[i] <= inc[i] ? cnt[i] + 1'b1 : cnt[i] - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb (NUM_REGS=12, ZERO_REG=1): directed vector table, bypass corner,
// randomized traffic against a reference model, and an asynchronous mid-run reset.
module tb_reg_file_sb;
    localparam int NREGS = 12;
    localparam int MAXC  = 3;
    localparam int NV    = 21;

    logic        clk;
    logic        reset;
    logic [3:0]  rs1, rs2, rd_imm, rd_wb, issue_rd;
    logic [31:0] out_rs1, out_rs2, write_imm, write_reg_data;
    logic        rs1_busy, rs2_busy, write_en_imm, write_reg, issue_valid;
    logic        issue_ready, err_underflow;

    int n_chk;
    int n_fail;

    logic [31:0] m_regs [16];
    int          m_cnt  [16];
    logic        m_err;

    typedef struct {
        logic [3:0]  rs1, rs2, rd_imm, rd_wb, ird;
        logic        we_imm, wb, iv;
        logic [31:0] imm, wbd;
        logic [31:0] e_rs1, e_rs2;
        logic        e_b1, e_b2, e_rdy, e_err;
    } vec_t;

    vec_t tv [NV];

    reg_file_sb #(
        .DATA_W(32), .NUM_REGS(NREGS), .ADDR_W(4), .PEND_W(2), .ZERO_REG(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .rs1(rs1), .rs2(rs2), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rd_imm(rd_imm), .write_imm(write_imm), .write_en_imm(write_en_imm),
        .rd_wb(rd_wb), .write_reg_data(write_reg_data), .write_reg(write_reg),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .err_underflow(err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic legal(input logic [3:0] a);
        return (int'(a) < NREGS) && (a != 4'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (!legal(a)) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (write_en_imm && rd_imm == a) return write_imm;
        if (write_reg && rd_wb == a) return write_reg_data;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [3:0] a);
        int c;
        if (!legal(a)) return 1'b0;
        c = m_cnt[a];
`ifdef REGFILE_BYPASS_EN
        if (write_reg && rd_wb == a && c > 0) c = c - 1;
`endif
        return c != 0;
    endfunction

    function automatic logic exp_ready();
        return !legal(issue_rd) || (m_cnt[issue_rd] < MAXC);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 32'd0;
            m_cnt[i]  = 0;
        end
        m_err = 1'b0;
    endfunction

    function automatic void model_update();
        logic rdy;
        rdy = exp_ready();
        if (write_reg && legal(rd_wb)) begin
            m_regs[rd_wb] = write_reg_data;
            if (m_cnt[rd_wb] == 0) m_err = 1'b1;
            else m_cnt[rd_wb] = m_cnt[rd_wb] - 1;
        end
        if (write_en_imm && legal(rd_imm)) m_regs[rd_imm] = write_imm;
        if (issue_valid && rdy && legal(issue_rd)) m_cnt[issue_rd] = m_cnt[issue_rd] + 1;
    endfunction

    task automatic check_model(input string tag);
        chk32({tag, "_out_rs1"}, out_rs1, exp_rd(rs1));
        chk32({tag, "_out_rs2"}, out_rs2, exp_rd(rs2));
        chk1({tag, "_rs1_busy"}, rs1_busy, exp_busy(rs1));
        chk1({tag, "_rs2_busy"}, rs2_busy, exp_busy(rs2));
        chk1({tag, "_issue_ready"}, issue_ready, exp_ready());
        chk1({tag, "_err"}, err_underflow, m_err);
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rs1 = 4'd0; rs2 = 4'd0;
        write_en_imm = 1'b0; rd_imm = 4'd0; write_imm = 32'd0;
        write_reg = 1'b0; rd_wb = 4'd0; write_reg_data = 32'd0;
        issue_valid = 1'b0; issue_rd = 4'd0;
    endtask

    task automatic rand_inputs();
        rs1 = 4'($urandom_range(0, 15));
        rs2 = 4'($urandom_range(0, 15));
        write_en_imm = ($urandom_range(0, 3) == 0);
        rd_imm = 4'($urandom_range(0, 15));
        write_imm = $urandom;
        write_reg = ($urandom_range(0, 2) == 0);
        rd_wb = 4'($urandom_range(0, 15));
        write_reg_data = $urandom;
        issue_valid = ($urandom_range(0, 1) == 0);
        issue_rd = 4'($urandom_range(0, 15));
    endtask

    function automatic vec_t mk(int r1, int r2, int wi, int ri, logic [31:0] di,
                                int wb, int rw, logic [31:0] dw, int iv, int ir,
                                logic [31:0] e1, logic [31:0] e2,
                                int b1, int b2, int rdy, int err);
        vec_t v;
        v.rs1 = 4'(r1); v.rs2 = 4'(r2);
        v.we_imm = (wi != 0); v.rd_imm = 4'(ri); v.imm = di;
        v.wb = (wb != 0); v.rd_wb = 4'(rw); v.wbd = dw;
        v.iv = (iv != 0); v.ird = 4'(ir);
        v.e_rs1 = e1; v.e_rs2 = e2;
        v.e_b1 = (b1 != 0); v.e_b2 = (b2 != 0); v.e_rdy = (rdy != 0); v.e_err = (err != 0);
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rs1 = v.rs1; rs2 = v.rs2;
        write_en_imm = v.we_imm; rd_imm = v.rd_imm; write_imm = v.imm;
        write_reg = v.wb; rd_wb = v.rd_wb; write_reg_data = v.wbd;
        issue_valid = v.iv; issue_rd = v.ird;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        idle();
        rs1 = 4'd3; rs2 = 4'd5; issue_rd = 4'd2;
        model_reset();
        #2;
        chk32("reset_out_rs1", out_rs1, 32'd0);
        chk32("reset_out_rs2", out_rs2, 32'd0);
        chk1("reset_rs1_busy", rs1_busy, 1'b0);
        chk1("reset_issue_ready", issue_ready, 1'b1);
        chk1("reset_err", err_underflow, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        //        rs1 rs2 wi ri imm           wb rw wbd           iv ir  e_rs1         e_rs2         b1 b2 rdy err
        tv[0]  = mk(1,  2,  0, 0, 0,            0, 0, 0,            1, 7,  0,            0,            0, 0, 1, 0);
        tv[1]  = mk(7,  0,  0, 0, 0,            0, 0, 0,            0, 7,  0,            0,            1, 0, 1, 0);
        tv[2]  = mk(3,  0,  1, 7, 32'hDEADBEEF, 1, 7, 32'h12345678, 0, 0,  0,            0,            0, 0, 1, 0);
        tv[3]  = mk(7,  7,  0, 0, 0,            0, 0, 0,            0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0);
        tv[4]  = mk(2,  0,  0, 0, 0,            0, 0, 0,            1, 2,  0,            0,            0, 0, 1, 0);
        tv[5]  = mk(2,  0,  0, 0, 0,            0, 0, 0,            1, 2,  0,            0,            1, 0, 1, 0);
        tv[6]  = mk(2,  0,  0, 0, 0,            0, 0, 0,            1, 2,  0,            0,            1, 0, 1, 0);
        tv[7]  = mk(2,  0,  0, 0, 0,            0, 0, 0,            1, 2,  0,            0,            1, 0, 0, 0);
        tv[8]  = mk(2,  0,  0, 0, 0,            0, 0, 0,            1, 2,  0,            0,            1, 0, 0, 0);
        tv[9]  = mk(5,  6,  0, 0, 0,            1, 2, 32'h00001111, 0, 2,  0,            0,            0, 0, 0, 0);
        tv[10] = mk(7,  3,  0, 0, 0,            1, 2, 32'h00002222, 1, 2,  32'hDEADBEEF, 0,            0, 0, 1, 0);
        tv[11] = mk(2,  2,  0, 0, 0,            0, 0, 0,            0, 2,  32'h00002222, 32'h00002222, 1, 1, 1, 0);
        tv[12] = mk(1,  0,  0, 0, 0,            1, 2, 32'h00003333, 0, 2,  0,            0,            0, 0, 1, 0);
        tv[13] = mk(2,  0,  0, 0, 0,            0, 0, 0,            0, 2,  32'h00003333, 0,            1, 0, 1, 0);
        tv[14] = mk(7,  0,  0, 0, 0,            1, 2, 32'h00004444, 0, 2,  32'hDEADBEEF, 0,            0, 0, 1, 0);
        tv[15] = mk(2,  2,  0, 0, 0,            0, 0, 0,            0, 2,  32'h00004444, 32'h00004444, 0, 0, 1, 0);
        tv[16] = mk(3,  0,  0, 0, 0,            1, 9, 32'hA5A5A5A5, 0, 0,  0,            0,            0, 0, 1, 0);
        tv[17] = mk(9,  0,  0, 0, 0,            0, 0, 0,            0, 0,  32'hA5A5A5A5, 0,            0, 0, 1, 1);
        tv[18] = mk(0,  13, 1, 0, 32'hFFFFFFFF, 1, 13, 32'hFFFFFFFF, 1, 0, 0,            0,            0, 0, 1, 1);
        tv[19] = mk(0,  13, 1, 12, 32'hFFFFFFFF, 1, 11, 32'h0B0B0B0B, 1, 13, 0,           0,            0, 0, 1, 1);
        tv[20] = mk(12, 11, 0, 0, 0,            0, 0, 0,            0, 0,  0,            32'h0B0B0B0B, 0, 0, 1, 1);

        for (int i = 0; i < NV; i++) begin
            apply(tv[i]);
            #3;
            chk32($sformatf("vec%0d_out_rs1", i), out_rs1, tv[i].e_rs1);
            chk32($sformatf("vec%0d_out_rs2", i), out_rs2, tv[i].e_rs2);
            chk1($sformatf("vec%0d_rs1_busy", i), rs1_busy, tv[i].e_b1);
            chk1($sformatf("vec%0d_rs2_busy", i), rs2_busy, tv[i].e_b2);
            chk1($sformatf("vec%0d_issue_ready", i), issue_ready, tv[i].e_rdy);
            chk1($sformatf("vec%0d_err", i), err_underflow, tv[i].e_err);
            clock_edge();
        end

        // Final writeback to reg 4 while it is being read.
        idle();
        issue_valid = 1'b1; issue_rd = 4'd4;
        clock_edge();
        idle();
        rs2 = 4'd4; write_reg = 1'b1; rd_wb = 4'd4; write_reg_data = 32'h00000055;
        #3;
`ifdef REGFILE_BYPASS_EN
        chk32("bypass_out_rs2", out_rs2, 32'h00000055);
        chk1("bypass_rs2_busy", rs2_busy, 1'b0);
`else
        chk32("nobypass_out_rs2", out_rs2, 32'h00000000);
        chk1("nobypass_rs2_busy", rs2_busy, 1'b1);
`endif
        clock_edge();
        idle();
        rs2 = 4'd4;
        #3;
        chk32("after_wb_out_rs2", out_rs2, 32'h00000055);
        chk1("after_wb_rs2_busy", rs2_busy, 1'b0);
        clock_edge();

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            #3;
            check_model($sformatf("rand%0d", i));
            clock_edge();
        end

        // Load regs 3 and 5, saturate reg 3, then reset between clock edges.
        idle();
        write_en_imm = 1'b1; rd_imm = 4'd3; write_imm = 32'h33330003;
        clock_edge();
        rd_imm = 4'd5; write_imm = 32'h55550005;
        clock_edge();
        idle();
        issue_valid = 1'b1; issue_rd = 4'd3;
        repeat (4) clock_edge();
        issue_valid = 1'b0; rs1 = 4'd3; rs2 = 4'd5;
        #2;
        check_model("pre_reset");
        reset = 1'b1;
        #1;
        chk32("midreset_out_rs1", out_rs1, 32'd0);
        chk32("midreset_out_rs2", out_rs2, 32'd0);
        chk1("midreset_rs1_busy", rs1_busy, 1'b0);
        chk1("midreset_rs2_busy", rs2_busy, 1'b0);
        chk1("midreset_issue_ready", issue_ready, 1'b1);
        chk1("midreset_err", err_underflow, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            #3;
            check_model($sformatf("post%0d", i));
            clock_edge();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
